// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg : shared types and constants for the bit-serial adder
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

   localparam int c_default_width = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/full_adder_cell.sv
// ============================================================================
// full_adder_cell : gate-level 1-bit full adder, shared with the ripple adders
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder_cell (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic C,
   output logic S
);

   assign S = A ^ B ^ Cin;
   assign C = (A & B) | (B & Cin) | (A & Cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder_4bit.sv
// ============================================================================
// serial_adder_4bit : bit-serial adder, one sum bit per clock, valid/ready I/O
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_adder_4bit
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = c_default_width
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             OV
);

   localparam int                 c_cnt_w   = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_bit_msm = c_cnt_w'(WIDTH - 2);
   localparam logic [c_cnt_w-1:0] c_bit_msb = c_cnt_w'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               cin_msb_q, cin_msb_d;
   logic               cout_q, cout_d;
   logic               ov_q, ov_d;

   logic               fa_s;
   logic               fa_c;

   full_adder_cell u_fa (
      .A   (opa_q[0]),
      .B   (opb_q[0]),
      .Cin (carry_q),
      .C   (fa_c),
      .S   (fa_s)
   );

   always_comb begin
      state_d   = state_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      sum_sr_d  = sum_sr_q;
      s_d       = s_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      cin_msb_d = cin_msb_q;
      cout_d    = cout_q;
      ov_d      = ov_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               opa_d    = A;
               opb_d    = B;
               carry_d  = Cin;
               cnt_d    = '0;
               sum_sr_d = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            // New sum bit enters at the MSB so bit 0 lands at position 0 after WIDTH shifts
            sum_sr_d = WIDTH'({fa_s, sum_sr_q} >> 1);
            opa_d    = opa_q >> 1;
            opb_d    = opb_q >> 1;
            carry_d  = fa_c;
            cnt_d    = cnt_q + c_cnt_w'(1);
            if (cnt_q == c_bit_msm) begin
               cin_msb_d = fa_c;
            end
            if (cnt_q == c_bit_msb) begin
               s_d     = sum_sr_d;
               cout_d  = fa_c;
               ov_d    = cin_msb_q ^ fa_c;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         opa_q     <= '0;
         opb_q     <= '0;
         sum_sr_q  <= '0;
         s_q       <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         cin_msb_q <= 1'b0;
         cout_q    <= 1'b0;
         ov_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         sum_sr_q  <= sum_sr_d;
         s_q       <= s_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         cin_msb_q <= cin_msb_d;
         cout_q    <= cout_d;
         ov_q      <= ov_d;
      end
   end

   assign in_ready  = (state_q == IDLE) & ~rst;
   assign out_valid = (state_q == DONE);
   assign S         = s_q;
   assign Cout      = cout_q;
   assign OV        = ov_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_4bit.sv
// ============================================================================
// tb_serial_adder_4bit : directed and exhaustive checks of the serial adder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder_4bit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       Cin = 1'b0;
   logic [3:0] A = 4'd0;
   logic [3:0] B = 4'd0;
   logic       in_ready;
   logic       out_valid;
   logic [3:0] S;
   logic       Cout;
   logic       OV;

   int checks = 0;
   int errors = 0;

   serial_adder_4bit #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Cout      (Cout),
      .OV        (OV)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 with the block back in IDLE.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input int stall);
      logic [4:0] sum;
      logic [3:0] s_exp;
      logic       ov_exp;
      int         k;
      int         low;
      sum    = 5'(a) + 5'(b) + 5'(ci);
      s_exp  = sum[3:0];
      ov_exp = (a[3] == b[3]) && (s_exp[3] != a[3]);

      check("in_ready_idle", 32'(in_ready), 32'd1);
      A = a; B = b; Cin = ci; in_valid = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      if (stall == 0) begin
         in_valid = 1'b0;
      end else begin
         A = ~a; B = ~b; Cin = ~ci;
      end
      k = 0;
      low = 0;
      while (!out_valid && k < 20) begin
         if (!in_ready) low++;
         @(posedge clk); #1;
         k++;
      end
      check("latency", 32'(k), 32'd4);
      check("result", {26'd0, Cout, OV, S}, {26'd0, sum[4], ov_exp, s_exp});
      for (int i = 0; i < stall; i++) begin
         if (!in_ready) low++;
         @(posedge clk); #1;
         check("hold", {25'd0, out_valid, Cout, OV, S}, {25'd0, 1'b1, sum[4], ov_exp, s_exp});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (!in_ready) low++;
      @(posedge clk); #1;
      check("back_idle", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
      check("ready_low", 32'(low), 32'(5 + stall));
   endtask

   initial begin
      #2;
      check("rst_state", {25'd0, in_ready, out_valid, Cout, OV, S}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(4'd3,  4'd5, 1'b0, 0);
      run_op(4'd15, 4'd1, 1'b0, 0);
      run_op(4'd7,  4'd0, 1'b1, 0);

      for (int v = 0; v < 512; v++) begin
         run_op(v[8:5], v[4:1], v[0], 0);
      end

      run_op(4'd6, 4'd7, 1'b1, 3);

      // Abort during the second RUN cycle; S/OV hold the previous nonzero result
      A = 4'd12; B = 4'd10; Cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_async", {25'd0, in_ready, out_valid, Cout, OV, S}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("rst_held", {30'd0, in_ready, out_valid}, 32'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
      run_op(4'd9, 4'd9, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
